mix_cols_iter: RTL and testbench
================================

// Module: mix_cols_iter
// PURPOSE
//  Sequential, parametrised AES MixColumns / InvMixColumns engine with valid/ready handshakes.
//  Processes COLS_PER_CYCLE columns per clock, so the GF(2^8) matrix logic is shared across columns.
//  Direction is selected per block at run time, not at elaboration.
//  Sits between ShiftRows and AddRoundKey in the iterative round datapath; encrypt and decrypt share one instance.
// PARAMETERS
//  COLS_PER_CYCLE  1  columns transformed per clock; legal values 1, 2, 4; any other value -> $error at elaboration
//  NUM_STEPS       4/COLS_PER_CYCLE (localparam)  processing cycles per block
// PORTS
//  clk        in   1    clock; all state changes on rising edge
//  rst        in   1    reset, synchronous, active-high
//  in_valid   in   1    in_state/in_inverse valid
//  in_ready   out  1    engine can accept a block
//  in_state   in   128  state; byte k = [127-8k -: 8]; column c = bytes 4c..4c+3 = [127-32c -: 32]
//  in_inverse in   1    0 = MixColumns, 1 = InvMixColumns; sampled at accept
//  out_valid  out  1    out_state valid
//  out_ready  in   1    consumer accepts out_state
//  out_state  out  128  transformed state, same byte/column mapping as in_state
//  out_inverse out 1    mode used for the block currently in out_state
//  busy       out  1    high in PROC or DONE
// BEHAVIOUR
//  Reset (rst=1 at an edge), effective at that edge:
//   - FSM goes to IDLE; col_idx=0.
//   - out_valid=0, out_state=0, out_inverse=0, busy=0.
//   - in_ready=0 while rst is high.
//   - Reset mid-PROC or mid-DONE discards the block; no partial output ever appears.
//  FSM IDLE -> PROC -> DONE -> IDLE:
//   - IDLE:
//     - in_ready=1.
//     - On in_valid&&in_ready: latch in_state into working reg and in_inverse into mode_r; col_idx=0; go to PROC.
//   - PROC:
//     - in_ready=0.
//     - Each cycle, replace columns col_idx..col_idx+COLS_PER_CYCLE-1 in place with the matrix result.
//     - col_idx += COLS_PER_CYCLE, wrapping mod 4.
//     - After the step that covers column 3, go to DONE.
//   - DONE:
//     - out_valid=1, out_state=working reg, out_inverse=mode_r.
//     - Hold all outputs stable until out_valid&&out_ready; then go to IDLE.
//     - out_valid=0 from the next cycle.
//  Latency and throughput:
//   - Accept edge at T; out_valid is first high after edge T+NUM_STEPS.
//     - CPC=1: 4 cycles. CPC=2: 2 cycles. CPC=4: 1 cycle.
//   - in_ready returns the cycle after the output handshake.
//   - Max throughput is one block per NUM_STEPS+2 cycles (out_ready held high).
//   - No overlap: a new input is never accepted in the same cycle as an output handshake.
//  Arithmetic (per column a0..a3 -> b0..b3, GF(2^8), poly 0x11B):
//   - Forward, circulant rows: b0 = 02*a0 ^ 03*a1 ^ 01*a2 ^ 01*a3; b1..b3 are successive right rotations of [02,03,01,01].
//   - Inverse: same structure with [0E,0B,0D,09].
//   - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00).
//  Mode isolation:
//   - in_inverse changes while busy have no effect on the block in flight.
//   - in_state changes while in_ready=0 are ignored.
//  Outputs:
//   - Registered only; no combinational path from in_* to out_*.
//   - The only combinational path is out_ready -> FSM next state.
// TESTING (run for COLS_PER_CYCLE = 1, 2 and 4)
//  - Forward vector:
//    - Stimulus: in_inverse=0, in_state=d4bf5d30e0b452aeb84111f11e2798e5.
//    - Required: out_state=046681e5e0cb199a48f8d37a2806264c, out_valid exactly NUM_STEPS cycles after accept.
//  - Inverse vector:
//    - Stimulus: in_inverse=1, in_state=046681e5e0cb199a48f8d37a2806264c.
//    - Required: out_state=d4bf5d30e0b452aeb84111f11e2798e5, out_inverse=1.
//  - Per-column check, forward, fixed vectors:
//    - Column 0 = db135345 -> 8e4da1bc, with other columns 01010101 -> 01010101.
//    - Zero state -> zero.
//  - Backpressure:
//    - Stimulus: out_ready=0 for 10 cycles after out_valid.
//    - Required: out_state/out_valid stable, in_ready=0 throughout; after out_ready pulses, in_ready=1 next cycle.
//  - Reset mid-PROC:
//    - Stimulus: assert rst 1 cycle after accept.
//    - Required: no out_valid for that block; a following block d4bf...98e5 yields 0466...264c.
//  - Random round trip:
//    - Stimulus: 200 random states, each passed forward then fed back with in_inverse=1; back-to-back blocks, random out_ready stalls.
//    - Required: identity in every case; mode toggled mid-PROC never corrupts a result.

Source files
------------

// File: rtl/mix_cols_iter_if.sv
// Handshake bundle for the iterative MixColumns engine: block in, block out, status.
interface mix_cols_iter_if;
  localparam int unsigned STATE_W = 128;

  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] in_state;
  logic               in_inverse;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] out_state;
  logic               out_inverse;
  logic               busy;

  modport slave (
    input  in_valid, in_state, in_inverse, out_ready,
    output in_ready, out_valid, out_state, out_inverse, busy
  );

  modport master (
    output in_valid, in_state, in_inverse, out_ready,
    input  in_ready, out_valid, out_state, out_inverse, busy
  );
endinterface

// File: rtl/mix_cols_iter.sv
// Iterative AES MixColumns / InvMixColumns engine; COLS_PER_CYCLE columns per clock,
// direction chosen per block, one shared instance for encrypt and decrypt rounds.
module mix_cols_iter #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic           clk,
  input  logic           rst,
  mix_cols_iter_if.slave bus
);

  localparam int unsigned NUM_COLS  = 4;
  localparam int unsigned COL_W     = 32;
  localparam int unsigned NUM_STEPS = NUM_COLS / COLS_PER_CYCLE;
  localparam logic [1:0]  IDX_STEP  = 2'(COLS_PER_CYCLE);
  localparam logic [1:0]  LAST_IDX  = 2'((NUM_STEPS - 1) * COLS_PER_CYCLE);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
    $error("mix_cols_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PROC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // One column through the circulant matrix; inverse coefficients built from x2/x4/x8.
  function automatic logic [COL_W-1:0] mix_col(input logic [COL_W-1:0] col, input logic inv);
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] b  [4];
    logic [1:0] r0, r1, r2, r3;
    a[0] = col[31:24];
    a[1] = col[23:16];
    a[2] = col[15:8];
    a[3] = col[7:0];
    for (int i = 0; i < 4; i++) begin
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
    for (int r = 0; r < 4; r++) begin
      r0 = 2'(r);
      r1 = 2'(r + 1);
      r2 = 2'(r + 2);
      r3 = 2'(r + 3);
      if (inv) begin
        b[r] = (x8[r0] ^ x4[r0] ^ x2[r0]) ^
               (x8[r1] ^ x2[r1] ^ a[r1]) ^
               (x8[r2] ^ x4[r2] ^ a[r2]) ^
               (x8[r3] ^ a[r3]);
      end else begin
        b[r] = x2[r0] ^ (x2[r1] ^ a[r1]) ^ a[r2] ^ a[r3];
      end
    end
    return {b[0], b[1], b[2], b[3]};
  endfunction

  state_e                   state_q, state_d;
  logic [1:0]               col_idx_q, col_idx_d;
  logic                     mode_q, mode_d;
  logic [COL_W-1:0]         work_q [NUM_COLS];
  logic [COL_W-1:0]         work_d [NUM_COLS];
  logic                     out_valid_q, out_valid_d;
  logic [NUM_COLS*COL_W-1:0] out_state_q, out_state_d;
  logic                     out_inverse_q, out_inverse_d;
  logic                     busy_q, busy_d;
  logic [1:0]               idx;

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      col_idx_q     <= '0;
      mode_q        <= 1'b0;
      for (int c = 0; c < int'(NUM_COLS); c++) work_q[c] <= '0;
      out_valid_q   <= 1'b0;
      out_state_q   <= '0;
      out_inverse_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_idx_q     <= col_idx_d;
      mode_q        <= mode_d;
      work_q        <= work_d;
      out_valid_q   <= out_valid_d;
      out_state_q   <= out_state_d;
      out_inverse_q <= out_inverse_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state, column stepping and output capture.
  always_comb begin
    state_d       = state_q;
    col_idx_d     = col_idx_q;
    mode_d        = mode_q;
    work_d        = work_q;
    out_state_d   = out_state_q;
    out_inverse_d = out_inverse_q;
    idx           = col_idx_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          for (int c = 0; c < int'(NUM_COLS); c++) begin
            work_d[c] = COL_W'(bus.in_state >> (96 - 32 * c));
          end
          mode_d    = bus.in_inverse;
          col_idx_d = '0;
          state_d   = S_PROC;
        end
      end
      S_PROC: begin
        for (int j = 0; j < int'(COLS_PER_CYCLE); j++) begin
          idx         = col_idx_q + 2'(j);
          work_d[idx] = mix_col(work_q[idx], mode_q);
        end
        col_idx_d = col_idx_q + IDX_STEP;
        if (col_idx_q == LAST_IDX) begin
          state_d       = S_DONE;
          out_state_d   = {work_d[0], work_d[1], work_d[2], work_d[3]};
          out_inverse_d = mode_q;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  // in_ready is a pure state decode, forced low while reset is held.
  assign bus.in_ready    = (state_q == S_IDLE) && !rst;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_state   = out_state_q;
  assign bus.out_inverse = out_inverse_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_mix_cols_iter.sv
// Scoreboard bench for mix_cols_iter; exercises COLS_PER_CYCLE = 1, 2 and 4 side by side.
module tb_mix_cols_iter;

  localparam logic [127:0] FWD_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] FWD_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] COL_IN  = 128'hdb135345010101010101010101010101;
  localparam logic [127:0] COL_OUT = 128'h8e4da1bc010101010101010101010101;

  typedef struct packed {
    logic [127:0] st;
    logic         inv;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   sel;
  logic         in_valid, in_inverse, out_ready;
  logic [127:0] in_state;
  logic         in_ready, out_valid, out_inverse, busy;
  logic [127:0] out_state;
  logic [2:0]   rdy_a, val_a, inv_a, busy_a;
  logic [127:0] st_a [3];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    mix_cols_iter_if bus ();
    assign bus.in_valid   = in_valid && (sel == 2'(k));
    assign bus.in_state   = in_state;
    assign bus.in_inverse = in_inverse;
    assign bus.out_ready  = out_ready && (sel == 2'(k));
    assign rdy_a[k]       = bus.in_ready;
    assign val_a[k]       = bus.out_valid;
    assign inv_a[k]       = bus.out_inverse;
    assign busy_a[k]      = bus.busy;
    assign st_a[k]        = bus.out_state;
    mix_cols_iter #(.COLS_PER_CYCLE(1 << k)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_inverse = 1'b0;
    busy        = 1'b0;
    out_state   = '0;
    for (int k = 0; k < 3; k++) begin
      if (sel == 2'(k)) begin
        in_ready    = rdy_a[k];
        out_valid   = val_a[k];
        out_inverse = inv_a[k];
        busy        = busy_a[k];
        out_state   = st_a[k];
      end
    end
  end

  // Reference: bit-serial GF(2^8) multiply and an explicit circulant matrix.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
    logic [7:0]   m [4];
    logic [7:0]   a [4];
    logic [7:0]   b;
    logic [127:0] o;
    if (inv) begin
      m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
    end else begin
      m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
    end
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = 8'(s >> (120 - 8 * (4 * c + k)));
      for (int r = 0; r < 4; r++) begin
        b = '0;
        for (int k = 0; k < 4; k++) b = b ^ gmul(m[(k - r + 4) % 4], a[k]);
        o = o | (128'(b) << (120 - 8 * (4 * c + r)));
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic int nsteps();
    return 4 >> sel;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one block until accepted; the expected result goes to the scoreboard.
  task automatic send(input logic [127:0] st, input logic inv, output logic ok, output int acc);
    exp_t e;
    ok = 1'b0;
    in_state = st;
    in_inverse = inv;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      tick();
    end
    acc = cyc;
    in_valid = 1'b0;
    if (ok) begin
      e.st = model(st, inv);
      e.inv = inv;
      sb_q.push_back(e);
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Send, wait for the result with junk on the idle input lines, stall, then drain.
  task automatic xfer(input logic [127:0] st, input logic inv, input int stall,
                      output logic got, output logic [127:0] ost, output logic oinv,
                      output int lat);
    logic ok;
    int   acc;
    got = 1'b0;
    ost = '0;
    oinv = 1'b0;
    lat = -1;
    send(st, inv, ok, acc);
    if (ok) begin
      for (int i = 0; i < 100 && !got; i++) begin
        if (out_valid) got = 1'b1;
        else begin
          in_inverse = 1'($urandom());
          in_state = rand128();
          tick();
        end
      end
      lat = cyc - acc;
      ost = out_state;
      oinv = out_inverse;
      if (got) begin
        repeat (stall) tick();
        take();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    sb_q.delete();
    tick();
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready cpc=%0d got %b want 0", 1 << sel, in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid cpc=%0d got %b want 0", 1 << sel, out_valid); end
    checks++; if (out_state !== 128'h0) begin errors++; $display("FAIL reset_out_state cpc=%0d got %h want 0", 1 << sel, out_state); end
    checks++; if (out_inverse !== 1'b0) begin errors++; $display("FAIL reset_out_inverse cpc=%0d got %b want 0", 1 << sel, out_inverse); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy cpc=%0d got %b want 0", 1 << sel, busy); end
    rst = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready cpc=%0d got %b want 1", 1 << sel, in_ready); end
  endtask

  task automatic test_fwd_vector();
    logic got, oinv;
    logic [127:0] ost;
    int lat;
    exp_t e;
    sb_q.delete();
    xfer(FWD_IN, 1'b0, 0, got, ost, oinv, lat);
    checks++;
    if (!got) begin errors++; $display("FAIL fwd_vec_timeout cpc=%0d no out_valid", 1 << sel); end
    else begin
      e = sb_q.pop_front();
      checks++; if (ost !== e.st) begin errors++; $display("FAIL fwd_vec_sb cpc=%0d got %h want %h", 1 << sel, ost, e.st); end
      checks++; if (ost !== FWD_OUT) begin errors++; $display("FAIL fwd_vec_const cpc=%0d got %h want %h", 1 << sel, ost, FWD_OUT); end
      checks++; if (lat !== nsteps()) begin errors++; $display("FAIL fwd_vec_latency cpc=%0d got %0d want %0d", 1 << sel, lat, nsteps()); end
      checks++; if (oinv !== 1'b0) begin errors++; $display("FAIL fwd_vec_mode cpc=%0d got %b want 0", 1 << sel, oinv); end
    end
  endtask

  task automatic test_inv_vector();
    logic got, oinv;
    logic [127:0] ost;
    int lat;
    exp_t e;
    sb_q.delete();
    xfer(FWD_OUT, 1'b1, 2, got, ost, oinv, lat);
    checks++;
    if (!got) begin errors++; $display("FAIL inv_vec_timeout cpc=%0d no out_valid", 1 << sel); end
    else begin
      e = sb_q.pop_front();
      checks++; if (ost !== e.st) begin errors++; $display("FAIL inv_vec_sb cpc=%0d got %h want %h", 1 << sel, ost, e.st); end
      checks++; if (ost !== FWD_IN) begin errors++; $display("FAIL inv_vec_const cpc=%0d got %h want %h", 1 << sel, ost, FWD_IN); end
      checks++; if (oinv !== 1'b1) begin errors++; $display("FAIL inv_vec_mode cpc=%0d got %b want 1", 1 << sel, oinv); end
    end
  endtask

  task automatic test_columns();
    logic got, oinv;
    logic [127:0] ost;
    int lat;
    exp_t e;
    sb_q.delete();
    xfer(COL_IN, 1'b0, 1, got, ost, oinv, lat);
    checks++;
    if (!got) begin errors++; $display("FAIL col_timeout cpc=%0d no out_valid", 1 << sel); end
    else begin
      e = sb_q.pop_front();
      checks++; if (ost !== e.st) begin errors++; $display("FAIL col_sb cpc=%0d got %h want %h", 1 << sel, ost, e.st); end
      checks++; if (ost !== COL_OUT) begin errors++; $display("FAIL col_const cpc=%0d got %h want %h", 1 << sel, ost, COL_OUT); end
    end
    xfer(128'h0, 1'b0, 0, got, ost, oinv, lat);
    checks++;
    if (!got) begin errors++; $display("FAIL zero_timeout cpc=%0d no out_valid", 1 << sel); end
    else begin
      e = sb_q.pop_front();
      checks++; if (ost !== 128'h0) begin errors++; $display("FAIL zero_state cpc=%0d got %h want 0", 1 << sel, ost); end
    end
  endtask

  task automatic test_backpressure();
    logic ok, got;
    int acc;
    exp_t e;
    sb_q.delete();
    got = 1'b0;
    send(FWD_IN, 1'b0, ok, acc);
    for (int i = 0; i < 100 && ok && !got; i++) begin
      if (out_valid) got = 1'b1;
      else tick();
    end
    checks++;
    if (!got) begin errors++; $display("FAIL bp_timeout cpc=%0d no out_valid", 1 << sel); end
    else begin
      e = sb_q.pop_front();
      for (int i = 0; i < 10; i++) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cpc=%0d cyc %0d got %b want 1", 1 << sel, i, out_valid); end
        checks++; if (out_state !== e.st) begin errors++; $display("FAIL bp_state cpc=%0d cyc %0d got %h want %h", 1 << sel, i, out_state, e.st); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cpc=%0d cyc %0d got %b want 0", 1 << sel, i, in_ready); end
        tick();
      end
      take();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after cpc=%0d got %b want 1", 1 << sel, in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_after cpc=%0d got %b want 0", 1 << sel, out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy_after cpc=%0d got %b want 0", 1 << sel, busy); end
    end
  endtask

  task automatic test_reset_mid_proc();
    logic ok, got, oinv, seen;
    logic [127:0] ost;
    int acc, lat;
    exp_t e;
    sb_q.delete();
    send(rand128(), 1'b0, ok, acc);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++; if (seen) begin errors++; $display("FAIL rst_mid_out_valid cpc=%0d got 1 want 0", 1 << sel); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy cpc=%0d got %b want 0", 1 << sel, busy); end
    xfer(FWD_IN, 1'b0, 0, got, ost, oinv, lat);
    checks++;
    if (!got) begin errors++; $display("FAIL rst_mid_next_timeout cpc=%0d no out_valid", 1 << sel); end
    else begin
      e = sb_q.pop_front();
      checks++; if (ost !== FWD_OUT) begin errors++; $display("FAIL rst_mid_next cpc=%0d got %h want %h", 1 << sel, ost, FWD_OUT); end
      checks++; if (ost !== e.st) begin errors++; $display("FAIL rst_mid_next_sb cpc=%0d got %h want %h", 1 << sel, ost, e.st); end
    end
  endtask

  task automatic test_back_to_back();
    logic ok, got;
    int acc, prev;
    exp_t e;
    sb_q.delete();
    out_ready = 1'b1;
    prev = -1;
    for (int b = 0; b < 4; b++) begin
      send(rand128(), 1'(b % 2), ok, acc);
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_accept cpc=%0d blk %0d never ready", 1 << sel, b); end
      else begin
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
          if (out_valid) got = 1'b1;
          else tick();
        end
        e = sb_q.pop_front();
        checks++; if (!got || out_state !== e.st) begin errors++; $display("FAIL b2b_state cpc=%0d blk %0d got %h want %h", 1 << sel, b, out_state, e.st); end
        checks++; if (out_inverse !== e.inv) begin errors++; $display("FAIL b2b_mode cpc=%0d blk %0d got %b want %b", 1 << sel, b, out_inverse, e.inv); end
        if (prev >= 0) begin
          checks++; if (acc - prev !== nsteps() + 2) begin errors++; $display("FAIL b2b_period cpc=%0d got %0d want %0d", 1 << sel, acc - prev, nsteps() + 2); end
        end
        prev = acc;
      end
    end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_round_trip(input int n);
    logic got, oinv;
    logic [127:0] r, o1, o2;
    int lat;
    exp_t e;
    sb_q.delete();
    for (int i = 0; i < n; i++) begin
      r = rand128();
      xfer(r, 1'b0, $urandom_range(0, 3), got, o1, oinv, lat);
      checks++;
      if (!got) begin errors++; $display("FAIL rt_fwd_timeout cpc=%0d iter %0d", 1 << sel, i); end
      else begin
        e = sb_q.pop_front();
        checks++; if (o1 !== e.st || oinv !== 1'b0) begin errors++; $display("FAIL rt_fwd cpc=%0d iter %0d got %h/%b want %h/0", 1 << sel, i, o1, oinv, e.st); end
        xfer(o1, 1'b1, $urandom_range(0, 3), got, o2, oinv, lat);
        checks++;
        if (!got) begin errors++; $display("FAIL rt_inv_timeout cpc=%0d iter %0d", 1 << sel, i); end
        else begin
          e = sb_q.pop_front();
          checks++; if (o2 !== e.st) begin errors++; $display("FAIL rt_inv_sb cpc=%0d iter %0d got %h want %h", 1 << sel, i, o2, e.st); end
          checks++; if (o2 !== r || oinv !== 1'b1) begin errors++; $display("FAIL rt_identity cpc=%0d iter %0d got %h/%b want %h/1", 1 << sel, i, o2, oinv, r); end
        end
      end
    end
  endtask

  initial begin
    in_valid = 1'b0;
    in_state = '0;
    in_inverse = 1'b0;
    out_ready = 1'b0;
    sel = 2'd0;
    for (int k = 0; k < 3; k++) begin
      sel = 2'(k);
      test_reset();
      test_fwd_vector();
      test_inv_vector();
      test_columns();
      test_backpressure();
      test_reset_mid_proc();
      test_back_to_back();
      test_round_trip(200);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
